// File: rtl/axi_lite_master_bridge_if.sv
// AXI4-Lite bus bundle between the core-side bridge (master) and the
// downstream address-translating adaptor / interconnect (slave).
interface axi_lite_master_bridge_if;
    // Read address channel
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [2:0]  m_arprot;
    // Read data channel
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    // Write address channel
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [2:0]  m_awprot;
    // Write data channel
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    // Write response channel
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    modport master (
        output m_araddr, m_arvalid, m_arprot, input m_arready,
        input  m_rdata, m_rresp, m_rvalid, output m_rready,
        output m_awaddr, m_awvalid, m_awprot, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input  m_bresp, m_bvalid, output m_bready
    );

    modport slave (
        input  m_araddr, m_arvalid, m_arprot, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready,
        input  m_awaddr, m_awvalid, m_awprot, output m_awready,
        input  m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Core load/store request -> single AXI4-Lite master transaction.
// One transaction in flight; every AXI output comes straight from a flop.
// Optional build macro: AXI_ERR_EN adds the err output, flagging a
// non-OKAY rresp/bresp alongside resp_valid.
module axi_lite_master_bridge #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
`ifdef AXI_ERR_EN
    output logic        err,
`endif
    output logic [31:0] resp_rdata,
    axi_lite_master_bridge_if.master bus
);

    // IDLE must encode as zero: the reset clears the whole register set.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RD_ADDR     = 3'd1,
        RD_DATA     = 3'd2,
        WR_ADDRDATA = 3'd3,
        WR_RESP     = 3'd4,
        DONE        = 3'd5
    } state_e;

    // All state and registered outputs live in one record so the next-state
    // logic can start from "hold everything" and change only what it needs.
    typedef struct packed {
        state_e      state;
        logic        arvalid;
        logic        rready;
        logic        awvalid;
        logic        wvalid;
        logic        bready;
        logic        resp_valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
`ifdef AXI_ERR_EN
        logic        err;
`endif
    } regs_t;

    regs_t r;
    regs_t r_nxt;

    // State register with synchronous active-low reset.
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r <= '0;
        end else begin
            r <= r_nxt;
        end
    end

    // Next-state and next registered-output decode.
    // NOTE: r_nxt gets a full default before the case so no path leaves any
    // field unassigned, which would otherwise infer a latch.
    always_comb begin
        r_nxt            = r;
        r_nxt.resp_valid = 1'b0;

        case (r.state)
            IDLE: begin
                if (req_valid) begin
                    r_nxt.addr  = req_addr;
                    r_nxt.wdata = req_wdata;
                    r_nxt.wstrb = req_wstrb;
`ifdef AXI_ERR_EN
                    r_nxt.err   = 1'b0;
`endif
                    if (req_we) begin
                        r_nxt.state   = WR_ADDRDATA;
                        r_nxt.awvalid = 1'b1;
                        r_nxt.wvalid  = 1'b1;
                    end else begin
                        r_nxt.state   = RD_ADDR;
                        r_nxt.arvalid = 1'b1;
                    end
                end
            end

            RD_ADDR: begin
                if (bus.m_arready) begin
                    r_nxt.arvalid = 1'b0;
                    r_nxt.rready  = 1'b1;
                    r_nxt.state   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (bus.m_rvalid) begin
                    r_nxt.rready     = 1'b0;
                    r_nxt.rdata      = bus.m_rdata;
                    r_nxt.resp_valid = 1'b1;
`ifdef AXI_ERR_EN
                    r_nxt.err        = (bus.m_rresp != 2'b00);
`endif
                    r_nxt.state      = DONE;
                end
            end

            WR_ADDRDATA: begin
                // Each channel drops its valid on its own handshake; a channel
                // already done (valid low) counts as complete.
                r_nxt.awvalid = r.awvalid && !bus.m_awready;
                r_nxt.wvalid  = r.wvalid  && !bus.m_wready;
                if (!r_nxt.awvalid && !r_nxt.wvalid) begin
                    r_nxt.bready = 1'b1;
                    r_nxt.state  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (bus.m_bvalid) begin
                    r_nxt.bready     = 1'b0;
                    r_nxt.resp_valid = 1'b1;
`ifdef AXI_ERR_EN
                    r_nxt.err        = (bus.m_bresp != 2'b00);
`endif
                    r_nxt.state      = DONE;
                end
            end

            DONE: begin
                r_nxt.state = IDLE;
            end

            default: begin
                r_nxt = '0;
            end
        endcase
    end

    assign req_ready  = (r.state == IDLE);
    assign resp_valid = r.resp_valid;
    assign resp_rdata = r.rdata;
`ifdef AXI_ERR_EN
    assign err        = r.err;
`else
    // Response codes are deliberately ignored in this build.
    logic unused_resp;
    assign unused_resp = &{1'b0, bus.m_rresp, bus.m_bresp};
`endif

    assign bus.m_araddr  = r.addr;
    assign bus.m_arvalid = r.arvalid;
    assign bus.m_arprot  = PROT;
    assign bus.m_rready  = r.rready;
    assign bus.m_awaddr  = r.addr;
    assign bus.m_awvalid = r.awvalid;
    assign bus.m_awprot  = PROT;
    assign bus.m_wdata   = r.wdata;
    assign bus.m_wstrb   = r.wstrb;
    assign bus.m_wvalid  = r.wvalid;
    assign bus.m_bready  = r.bready;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge; the slave side is driven
// step by step from the stimulus block. Build with AXI_ERR_EN to also
// exercise the err flag.
module tb_axi_lite_master_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
`ifdef AXI_ERR_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    axi_lite_master_bridge_if bus ();

    axi_lite_master_bridge #(.PROT(3'b000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
`ifdef AXI_ERR_EN
        .err        (err),
`endif
        .resp_rdata (resp_rdata),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slave();
        bus.m_arready = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = 2'b00;
        bus.m_rvalid  = 1'b0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bresp   = 2'b00;
        bus.m_bvalid  = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        idle_slave();

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_arvalid", bus.m_arvalid, 0);
        check("rst_rready", bus.m_rready, 0);
        check("rst_awvalid", bus.m_awvalid, 0);
        check("rst_wvalid", bus.m_wvalid, 0);
        check("rst_bready", bus.m_bready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_araddr", bus.m_araddr, 32'h0);
        check("rst_wdata", bus.m_wdata, 32'h0);
        check("rst_wstrb", bus.m_wstrb, 4'h0);
`ifdef AXI_ERR_EN
        check("rst_err", err, 0);
`endif
        rstn = 1'b1;
        tick();

        // ---------------- read, zero-wait slave ----------------
        req_valid     = 1'b1;
        req_we        = 1'b0;
        req_addr      = 32'h8000_0010;
        bus.m_arready = 1'b1;
        bus.m_rvalid  = 1'b1;
        bus.m_rdata   = 32'hDEAD_BEEF;
        check("rd0_c0_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("rd0_c1_arvalid", bus.m_arvalid, 1);
        check("rd0_c1_araddr", bus.m_araddr, 32'h8000_0010);
        check("rd0_c1_arprot", bus.m_arprot, 3'b000);
        check("rd0_c1_rready", bus.m_rready, 0);
        check("rd0_c1_req_ready", req_ready, 0);
        tick();
        check("rd0_c2_arvalid", bus.m_arvalid, 0);
        check("rd0_c2_rready", bus.m_rready, 1);
        check("rd0_c2_req_ready", req_ready, 0);
        tick();
        check("rd0_c3_resp_valid", resp_valid, 1);
        check("rd0_c3_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("rd0_c3_rready", bus.m_rready, 0);
        check("rd0_c3_req_ready", req_ready, 0);
        tick();
        check("rd0_c4_resp_valid", resp_valid, 0);
        check("rd0_c4_req_ready", req_ready, 1);
        idle_slave();

        // ---------------- write, awready late, wready immediate ----------------
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h0000_0010;
        req_wdata    = 32'h1234_5678;
        req_wstrb    = 4'b0011;
        bus.m_wready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("wr1_c1_awvalid", bus.m_awvalid, 1);
        check("wr1_c1_wvalid", bus.m_wvalid, 1);
        check("wr1_c1_awaddr", bus.m_awaddr, 32'h10);
        check("wr1_c1_awprot", bus.m_awprot, 3'b000);
        check("wr1_c1_wdata", bus.m_wdata, 32'h1234_5678);
        check("wr1_c1_wstrb", bus.m_wstrb, 4'b0011);
        check("wr1_c1_arvalid", bus.m_arvalid, 0);
        tick();
        check("wr1_c2_wvalid", bus.m_wvalid, 0);
        check("wr1_c2_awvalid", bus.m_awvalid, 1);
        check("wr1_c2_awaddr", bus.m_awaddr, 32'h10);
        check("wr1_c2_bready", bus.m_bready, 0);
        tick();
        check("wr1_c3_awvalid", bus.m_awvalid, 1);
        check("wr1_c3_awaddr", bus.m_awaddr, 32'h10);
        check("wr1_c3_bready", bus.m_bready, 0);
        bus.m_awready = 1'b1;
        tick();
        bus.m_awready = 1'b0;
        check("wr1_c4_awvalid", bus.m_awvalid, 0);
        check("wr1_c4_bready", bus.m_bready, 1);
        check("wr1_c4_resp_valid", resp_valid, 0);
        bus.m_bvalid = 1'b1;
        tick();
        bus.m_bvalid = 1'b0;
        check("wr1_c5_resp_valid", resp_valid, 1);
        check("wr1_c5_bready", bus.m_bready, 0);
        check("wr1_c5_rdata_hold", resp_rdata, 32'hDEAD_BEEF);
        tick();
        check("wr1_c6_resp_valid", resp_valid, 0);
        check("wr1_c6_req_ready", req_ready, 1);
        idle_slave();

        // ---------------- read, arready 5-cycle stall, rvalid 4-cycle stall ----------------
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0ABC;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("rd2_ar_arvalid", bus.m_arvalid, 1);
            check("rd2_ar_araddr", bus.m_araddr, 32'h0000_0ABC);
            check("rd2_ar_req_ready", req_ready, 0);
            if (i == 5) bus.m_arready = 1'b1;
            tick();
        end
        bus.m_arready = 1'b0;
        check("rd2_arvalid_drop", bus.m_arvalid, 0);
        for (int i = 0; i < 5; i++) begin
            check("rd2_r_rready", bus.m_rready, 1);
            check("rd2_r_resp_valid", resp_valid, 0);
            check("rd2_r_req_ready", req_ready, 0);
            if (i == 4) begin
                bus.m_rvalid = 1'b1;
                bus.m_rdata  = 32'hCAFE_F00D;
            end
            tick();
        end
        bus.m_rvalid = 1'b0;
        // The still-pending request becomes the write of the next step.
        req_we        = 1'b1;
        req_addr      = 32'h0000_0020;
        req_wdata     = 32'hA5A5_A5A5;
        req_wstrb     = 4'hF;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        check("rd2_resp_valid", resp_valid, 1);
        check("rd2_resp_rdata", resp_rdata, 32'hCAFE_F00D);
        check("rd2_done_req_ready", req_ready, 0);
        tick();
        check("rd2_pulse_end", resp_valid, 0);
        check("rd2_idle_req_ready", req_ready, 1);
        check("rd2_idle_awvalid", bus.m_awvalid, 0);

        // ---------------- back-to-back write then read, req_valid held ----------------
        tick();
        check("b2b_wr_awvalid", bus.m_awvalid, 1);
        check("b2b_wr_wvalid", bus.m_wvalid, 1);
        check("b2b_wr_arvalid", bus.m_arvalid, 0);
        check("b2b_wr_awaddr", bus.m_awaddr, 32'h20);
        check("b2b_wr_wdata", bus.m_wdata, 32'hA5A5_A5A5);
        req_we       = 1'b0;
        req_addr     = 32'h0000_0030;
        bus.m_bvalid = 1'b1;
        tick();
        check("b2b_wr_bready", bus.m_bready, 1);
        check("b2b_wr_aw_w_clear", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 3'b000);
        tick();
        check("b2b_wr_resp_valid", resp_valid, 1);
        check("b2b_wr_arvalid_done", bus.m_arvalid, 0);
        tick();
        check("b2b_idle_req_ready", req_ready, 1);
        check("b2b_idle_resp_valid", resp_valid, 0);
        idle_slave();
        bus.m_arready = 1'b1;
        bus.m_rvalid  = 1'b1;
        bus.m_rdata   = 32'h0BAD_F00D;
        tick();
        req_valid = 1'b0;
        check("b2b_rd_arvalid", bus.m_arvalid, 1);
        check("b2b_rd_araddr", bus.m_araddr, 32'h30);
        check("b2b_rd_no_aw_w", {bus.m_awvalid, bus.m_wvalid}, 2'b00);
        tick();
        check("b2b_rd_rready", bus.m_rready, 1);
        tick();
        check("b2b_rd_resp_valid", resp_valid, 1);
        check("b2b_rd_resp_rdata", resp_rdata, 32'h0BAD_F00D);
        tick();
        check("b2b_rd_pulse_end", resp_valid, 0);
        idle_slave();

        // ---------------- reset while in RD_DATA ----------------
        req_valid     = 1'b1;
        req_we        = 1'b0;
        req_addr      = 32'h0000_0040;
        bus.m_arready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("mrst_pre_rready", bus.m_rready, 1);
        rstn         = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h5555_AAAA;
        tick();
        check("mrst_valids", {bus.m_arvalid, bus.m_rready, bus.m_awvalid, bus.m_wvalid, bus.m_bready}, 5'b0);
        check("mrst_req_ready", req_ready, 1);
        check("mrst_resp_valid", resp_valid, 0);
        check("mrst_resp_rdata", resp_rdata, 32'h0);
        rstn = 1'b1;
        idle_slave();
        tick();
        check("mrst_after_resp_valid", resp_valid, 0);
        check("mrst_after_req_ready", req_ready, 1);
        tick();

        // ---------------- error response, then clean read ----------------
        req_valid     = 1'b1;
        req_we        = 1'b1;
        req_addr      = 32'h0000_0050;
        req_wdata     = 32'h0000_00FF;
        req_wstrb     = 4'b0001;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.m_bvalid  = 1'b1;
        bus.m_bresp   = 2'b10;
        tick();
        req_valid = 1'b0;
        tick();
        check("err_wr_bready", bus.m_bready, 1);
        tick();
        check("err_wr_resp_valid", resp_valid, 1);
`ifdef AXI_ERR_EN
        check("err_wr_err", err, 1);
`endif
        tick();
`ifdef AXI_ERR_EN
        check("err_wr_err_hold", err, 1);
`endif
        idle_slave();
        req_valid     = 1'b1;
        req_we        = 1'b0;
        req_addr      = 32'h0000_0060;
        bus.m_arready = 1'b1;
        bus.m_rvalid  = 1'b1;
        bus.m_rresp   = 2'b00;
        bus.m_rdata   = 32'h1122_3344;
        tick();
        req_valid = 1'b0;
`ifdef AXI_ERR_EN
        check("err_rd_cleared", err, 0);
`endif
        tick();
        tick();
        check("err_rd_resp_valid", resp_valid, 1);
        check("err_rd_resp_rdata", resp_rdata, 32'h1122_3344);
`ifdef AXI_ERR_EN
        check("err_rd_err", err, 0);
`endif
        tick();
        idle_slave();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
